// File: rtl/clk_en_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_pkg
// Description : Shared constants and types for the clk_mst-domain clock
//               enable generator (clk_en_gen / clk_en_chan).
//               Contents:
//                 CNT_WIDTH_DEF - default divide/phase value width
//                 NUM_CH_MAX    - largest supported channel count
//                 CH_IDX_W      - width of the cfg_ch channel selector
//                 DIV_PPU       - PPU enable divide ratio
//                 DIV_CPU       - CPU enable divide ratio
//                 clk_en_ch_t   - per-channel state layout at default width
// Revision    : 1.0 - initial release
// ============================================================================
package clk_en_pkg;

    localparam int CNT_WIDTH_DEF = 5;
    localparam int NUM_CH_MAX    = 8;
    localparam int CH_IDX_W      = $clog2(NUM_CH_MAX);
    localparam int DIV_PPU       = 5;
    localparam int DIV_CPU       = 12;

    // Per-channel state at the default counter width. The channel module keeps
    // the same fields as individual registers so that CNT_WIDTH can be
    // overridden per instance.
    typedef struct packed {
        logic [CNT_WIDTH_DEF-1:0] cnt;   // down-counter, strobe at zero
        logic [CNT_WIDTH_DEF-1:0] div;   // divide ratio in force
        logic [CNT_WIDTH_DEF-1:0] pdiv;  // divide ratio waiting for commit
        logic [CNT_WIDTH_DEF-1:0] ph;    // realign phase offset
        logic                     pend;  // pdiv is waiting for commit
    } clk_en_ch_t;

endpackage : clk_en_pkg
`default_nettype wire

// File: rtl/clk_en_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_chan
// Description : One clock-enable channel: programmable down-counter divider,
//               pending-divide register committed at terminal count (or on a
//               realign), and an enable-domain reset that deasserts after
//               RST_EN_LENGTH strobes.
//               Optional feature macro: CLK_EN_PHASE_EN (phase register and
//               sync_req realign; without it both inputs are ignored).
// Ports       : clk_mst   - master clock
//               rst_mst   - synchronous active-low reset
//               cfg_we    - accepted configuration targets this channel
//               cfg_div   - new divide ratio (0 is treated as 1)
//               cfg_phase - new phase offset for realign
//               sync_req  - realign request (all channels at once)
//               clk_en    - registered single-cycle enable strobe
//               rst_en    - active-low reset, released on the Nth strobe
//               pend      - a divide change is waiting for commit
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int                   CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter logic [CNT_WIDTH-1:0] DIV_INIT      = CNT_WIDTH'(DIV_PPU),
    parameter int                   RST_EN_LENGTH = 4
) (
    input  logic                 clk_mst,
    input  logic                 rst_mst,
    input  logic                 cfg_we,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic [CNT_WIDTH-1:0] cfg_phase,
    input  logic                 sync_req,
    output logic                 clk_en,
    output logic                 rst_en,
    output logic                 pend
);

    localparam int                   RST_CNT_W  = $clog2(RST_EN_LENGTH + 1);
    localparam logic [RST_CNT_W-1:0] c_rst_len  = RST_CNT_W'(RST_EN_LENGTH);
    localparam logic [RST_CNT_W-1:0] c_rst_last = RST_CNT_W'(RST_EN_LENGTH - 1);
    // A zero divide would never reach a reload value; treat it as 1.
    localparam logic [CNT_WIDTH-1:0] c_div_rst  =
        (DIV_INIT == '0) ? CNT_WIDTH'(1) : DIV_INIT;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_div;
    logic [CNT_WIDTH-1:0] r_pdiv;
    logic                 r_pend;
    logic                 r_clk_en;
    logic                 r_rst_en;
    logic [RST_CNT_W-1:0] r_pcnt;

    logic [CNT_WIDTH-1:0] w_eff_div;
    logic [CNT_WIDTH-1:0] w_eff_max;
    logic [CNT_WIDTH-1:0] w_cfg_div;
    logic                 w_sync;
    logic [CNT_WIDTH-1:0] w_sync_cnt;

    // Divide used for any reload this cycle: a pending value takes over at
    // the reload, so the running period always completes first.
    assign w_eff_div = r_pend ? r_pdiv : r_div;
    assign w_eff_max = w_eff_div - CNT_WIDTH'(1);  // eff_div is never 0
    assign w_cfg_div = (cfg_div == '0) ? CNT_WIDTH'(1) : cfg_div;

`ifdef CLK_EN_PHASE_EN
    logic [CNT_WIDTH-1:0] r_ph;

    always_ff @(posedge clk_mst) begin
        if (!rst_mst) begin
            r_ph <= '0;
        end else if (cfg_we) begin
            r_ph <= cfg_phase;
        end
    end

    // A phase beyond the period would skip strobes; clamp to the last count.
    assign w_sync     = sync_req;
    assign w_sync_cnt = (r_ph < w_eff_max) ? r_ph : w_eff_max;
`else
    logic w_unused_phase;

    assign w_unused_phase = ^{cfg_phase, sync_req};
    assign w_sync         = 1'b0;
    assign w_sync_cnt     = '0;
`endif

    // Divider and pending-divide register. A config written on the same edge
    // as a realign lands after the realign's commit, so it stays pending.
    always_ff @(posedge clk_mst) begin
        if (!rst_mst) begin
            r_cnt    <= '0;
            r_div    <= c_div_rst;
            r_pdiv   <= c_div_rst;
            r_pend   <= 1'b0;
            r_clk_en <= 1'b0;
        end else begin
            if (w_sync) begin
                r_cnt    <= w_sync_cnt;
                r_div    <= w_eff_div;
                r_pend   <= 1'b0;
                r_clk_en <= 1'b0;
            end else if (r_cnt == '0) begin
                r_cnt    <= w_eff_max;
                r_div    <= w_eff_div;
                r_pend   <= 1'b0;
                r_clk_en <= 1'b1;
            end else begin
                r_cnt    <= r_cnt - CNT_WIDTH'(1);
                r_clk_en <= 1'b0;
            end

            if (cfg_we) begin
                r_pend <= 1'b1;
                r_pdiv <= w_cfg_div;
            end
        end
    end

    // Enable-domain reset: count strobes seen, release on the last one.
    always_ff @(posedge clk_mst) begin
        if (!rst_mst) begin
            r_pcnt   <= '0;
            r_rst_en <= 1'b0;
        end else if (r_clk_en && (r_pcnt != c_rst_len)) begin
            r_pcnt <= r_pcnt + RST_CNT_W'(1);
            if (r_pcnt == c_rst_last) begin
                r_rst_en <= 1'b1;
            end
        end
    end

    assign clk_en = r_clk_en;
    assign rst_en = r_rst_en;
    assign pend   = r_pend;

endmodule : clk_en_chan
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_gen
// Description : Clock-enable and enable-domain reset generator for the
//               clk_mst domain. NUM_CH channels, each a runtime-programmable
//               integer divider of clk_mst with its own active-low reset.
//               Optional feature macro: CLK_EN_PHASE_EN (phase offsets and
//               sync_req realign of all channels).
// Ports       : clk_mst   - master clock
//               rst_mst   - synchronous active-low reset
//               cfg_valid - configuration request
//               cfg_ready - no divide change pending, request can be taken
//               cfg_ch    - target channel
//               cfg_div   - new divide ratio
//               cfg_phase - new phase offset
//               cfg_err   - pulse: accepted request named a missing channel
//               sync_req  - realign all channels
//               clk_en    - per-channel registered enable strobes
//               rst_en    - per-channel active-low resets
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                          NUM_CH        = 2,
    parameter int                          CNT_WIDTH     = CNT_WIDTH_DEF,
    parameter logic [NUM_CH*CNT_WIDTH-1:0] DIV_INIT      =
        {CNT_WIDTH_DEF'(DIV_CPU), CNT_WIDTH_DEF'(DIV_PPU)},
    parameter int                          RST_EN_LENGTH = 4
) (
    input  logic                 clk_mst,
    input  logic                 rst_mst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_IDX_W-1:0]  cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic [CNT_WIDTH-1:0] cfg_phase,
    output logic                 cfg_err,
    input  logic                 sync_req,
    output logic [NUM_CH-1:0]    clk_en,
    output logic [NUM_CH-1:0]    rst_en
);

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_cfg_we;
    logic              w_accept;
    logic              w_in_range;
    logic              r_cfg_err;

    // Only one divide change may be in flight across all channels.
    assign cfg_ready  = ~|w_pend;
    assign w_accept   = cfg_valid & cfg_ready;
    assign w_in_range = (32'(cfg_ch) < NUM_CH);

    // Out-of-range requests are consumed but only flagged.
    always_ff @(posedge clk_mst) begin
        if (!rst_mst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept & ~w_in_range;
        end
    end

    assign cfg_err = r_cfg_err;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            assign w_cfg_we[g] = w_accept && (cfg_ch == CH_IDX_W'(g));

            clk_en_chan #(
                .CNT_WIDTH     (CNT_WIDTH),
                .DIV_INIT      (DIV_INIT[g*CNT_WIDTH +: CNT_WIDTH]),
                .RST_EN_LENGTH (RST_EN_LENGTH)
            ) u_chan (
                .clk_mst   (clk_mst),
                .rst_mst   (rst_mst),
                .cfg_we    (w_cfg_we[g]),
                .cfg_div   (cfg_div),
                .cfg_phase (cfg_phase),
                .sync_req  (sync_req),
                .clk_en    (clk_en[g]),
                .rst_en    (rst_en[g]),
                .pend      (w_pend[g])
            );
        end
    endgenerate

endmodule : clk_en_gen
`default_nettype wire
